// File: rtl/fetch_redirect_unit.sv
// IF-stage PC generator and fetch buffer. Issues sequential imem reads, queues {pc,instr}
// for ID, and applies decode redirects by retargeting the PC and discarding stale responses.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic        flush_o
);
    localparam int PW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CW = $clog2(FB_DEPTH + 1);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] fb_hd_q, fb_hd_d, fb_tl_q, fb_tl_d;
    logic [PW-1:0] iq_hd_q, iq_hd_d, iq_tl_q, iq_tl_d;

    logic [31:0] fb_pc_q    [FB_DEPTH];
    logic [31:0] fb_instr_q [FB_DEPTH];
    logic [31:0] iq_pc_q    [FB_DEPTH];

    logic        accept, push, pop;
    logic [CW:0] occ;
    logic        unused_pc_lsb;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign if_valid  = (cnt_q != '0);
    assign if_pc     = if_valid ? fb_pc_q[fb_hd_q] : '0;
    assign if_instr  = if_valid ? fb_instr_q[fb_hd_q] : '0;
    assign imem_addr = pc_q;
    assign flush_o   = redirect_i;

    assign pop  = if_valid & id_ready & ~redirect_i;
    assign push = imem_rvalid & (discard_q == '0) & ~redirect_i;

    // A slot freed by this cycle's pop is reusable at once; needed for 1 word/cycle.
    assign occ      = {1'b0, inflight_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
    assign imem_req = (state_q != ST_BOOT) & ~redirect_i & (occ < (CW+1)'(FB_DEPTH));
    assign accept   = imem_req & imem_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = accept ? pc_q + 32'd4 : pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
        discard_d  = discard_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        fb_hd_d    = pop  ? nxt(fb_hd_q) : fb_hd_q;
        fb_tl_d    = push ? nxt(fb_tl_q) : fb_tl_q;
        iq_hd_d    = imem_rvalid ? nxt(iq_hd_q) : iq_hd_q;
        iq_tl_d    = accept ? nxt(iq_tl_q) : iq_tl_q;
        if (imem_rvalid && discard_q != '0)
            discard_d = discard_q - 1'b1;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_DRAIN: if (discard_d == '0) state_d = ST_RUN;
            default:  ;
        endcase
        // The in-flight PC queue keeps advancing: stale entries retire with their responses.
        if (redirect_i) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            discard_d = inflight_q - CW'(imem_rvalid);
            cnt_d     = '0;
            fb_hd_d   = '0;
            fb_tl_d   = '0;
            state_d   = (discard_d != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            cnt_q      <= '0;
            fb_hd_q    <= '0;
            fb_tl_q    <= '0;
            iq_hd_q    <= '0;
            iq_tl_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            fb_hd_q    <= fb_hd_d;
            fb_tl_q    <= fb_tl_d;
            iq_hd_q    <= iq_hd_d;
            iq_tl_q    <= iq_tl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            iq_pc_q[iq_tl_q] <= pc_q;
        if (push) begin
            fb_pc_q[fb_tl_q]    <= iq_pc_q[iq_hd_q];
            fb_instr_q[fb_tl_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: in-order memory model with selectable latency, expected
// fetch stream queued by the stimulus and consumed by an independent monitor.
module tb_fetch_redirect_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i, imem_req, imem_ready, imem_rvalid;
    logic        if_valid, id_ready, flush_o;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;

    fetch_redirect_unit #(.RESET_PC(32'h0), .FB_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t       mq[$];
    logic [31:0] exp_pc[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    int total = 0, bad = 0, cyc = 0, lat = 1, nacc = 0, npop = 0;
    logic idr = 1'b1, rdy = 1'b1;
    logic        log_req[0:1023], log_vld[0:1023], log_flush[0:1023], log_rv[0:1023];
    logic [31:0] log_addr[0:1023], log_pc[0:1023];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(base + 32'(4 * i));
    endtask

    // One clock cycle: inputs change at negedge, memory answers due requests, log after settle.
    task automatic step(input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        id_ready = idr; imem_ready = rdy; redirect_i = redir; redirect_pc = rpc;
        imem_rvalid = 1'b0; imem_rdata = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].a);
            mq.delete(0);
        end
        if (redir) exp_pc.delete();
        #1;
        log_req[cyc] = imem_req; log_addr[cyc] = imem_addr; log_flush[cyc] = flush_o;
        log_vld[cyc] = if_valid; log_pc[cyc] = if_pc; log_rv[cyc] = imem_rvalid;
        if (imem_req && imem_ready) begin
            mq.push_back('{imem_addr, cyc + lat});
            acc_addr.push_back(imem_addr);
            acc_cyc.push_back(cyc);
            nacc++;
        end
        @(posedge clk);
    endtask

    task automatic quiesce();
        idr = 1'b0;
        repeat (6) step(1'b0, 32'h0);
    endtask

    // Monitor: every word ID takes must be the next expected one.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && if_valid && id_ready && !redirect_i) begin
            npop++;
            if (exp_pc.size() == 0) begin
                total++; bad++;
                $display("FAIL mon_unexpected: got pc %h expected no word", if_pc);
            end else begin
                logic [31:0] e;
                e = exp_pc.pop_front();
                check("mon_pc", if_pc, e);
                check("mon_instr", if_instr, memf(e));
            end
        end
    end

    initial begin
        int c, na, np0;
        redirect_i = 0; redirect_pc = 0; id_ready = 1; imem_ready = 1;
        imem_rvalid = 0; imem_rdata = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", imem_req, 0);     check("rst_addr", imem_addr, 0);
        check("rst_vld", if_valid, 0);     check("rst_pc", if_pc, 0);
        check("rst_instr", if_instr, 0);   check("rst_flush", flush_o, 0);

        // 1: streaming after BOOT
        push_stream(32'h0, 64);
        @(negedge clk); rst_n = 1'b1; #1;
        check("boot_req", imem_req, 0);
        c = cyc;
        repeat (8) step(1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            check("t1_req", log_req[c+k], 1);
            check("t1_addr", log_addr[c+k], 32'(4 * (k - 1)));
            if (k >= 3) begin
                check("t1_vld", log_vld[c+k], 1);
                check("t1_pc", log_pc[c+k], 32'(4 * (k - 3)));
            end
        end

        // 2: ID stall holds exactly FB_DEPTH words and stops requests
        idr = 1'b0;
        repeat (5) step(1'b0, 32'h0);
        check("t2_held", 32'(nacc - npop), 2);
        check("t2_req_drop", log_req[cyc], 0);
        idr = 1'b1;
        repeat (6) step(1'b0, 32'h0);

        // 3: redirect with two words in flight, no same-cycle response
        quiesce();
        lat = 3; idr = 1'b1;
        step(1'b1, 32'h10); c = cyc;
        step(1'b0, 32'h0); step(1'b0, 32'h0);
        check("t3_acc0", acc_addr[acc_addr.size()-2], 32'h10);
        check("t3_acc0_cyc", 32'(acc_cyc[acc_cyc.size()-2]), 32'(c + 1));
        check("t3_acc1", acc_addr[acc_addr.size()-1], 32'h14);
        step(1'b1, 32'h203);
        push_stream(32'h200, 64);
        check("t3_req_off", log_req[cyc], 0);
        check("t3_flush", log_flush[cyc], 1);
        na = acc_addr.size(); np0 = npop;
        repeat (12) step(1'b0, 32'h0);
        check("t3_first_acc", acc_addr[na], 32'h200);
        check("t3_delivered", 32'(npop > np0), 1);

        // 4: redirect coinciding with the response for 0x10
        quiesce();
        lat = 2; idr = 1'b1;
        step(1'b1, 32'h10); c = cyc;
        step(1'b0, 32'h0); step(1'b0, 32'h0);
        step(1'b1, 32'h400);
        push_stream(32'h400, 64);
        check("t4_rv_same", log_rv[cyc], 1);
        repeat (8) step(1'b0, 32'h0);
        check("t4_flush_c1", log_flush[c+1], 0);
        check("t4_flush_c2", log_flush[c+2], 0);
        check("t4_flush_c3", log_flush[c+3], 1);
        check("t4_flush_c4", log_flush[c+4], 0);

        // 5: second redirect while draining, first-target word still in flight
        quiesce();
        lat = 3; idr = 1'b1;
        step(1'b1, 32'h10);
        step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        step(1'b0, 32'h0);
        check("t5_acc_first_tgt", acc_addr[acc_addr.size()-1], 32'h100);
        step(1'b1, 32'h300);
        push_stream(32'h300, 64);
        check("t5_rv_same", log_rv[cyc], 1);
        na = acc_addr.size(); np0 = npop;
        repeat (12) step(1'b0, 32'h0);
        check("t5_first_acc", acc_addr[na], 32'h300);
        check("t5_delivered", 32'(npop > np0), 1);

        // 6: address wrap, then reset mid-stream
        quiesce();
        lat = 1; idr = 1'b1;
        step(1'b1, 32'hFFFF_FFF8);
        push_stream(32'hFFFF_FFF8, 64);
        na = acc_addr.size();
        repeat (6) step(1'b0, 32'h0);
        check("t6_wrap0", acc_addr[na], 32'hFFFF_FFF8);
        check("t6_wrap1", acc_addr[na+1], 32'hFFFF_FFFC);
        check("t6_wrap2", acc_addr[na+2], 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b0; imem_rvalid = 1'b0;
        mq.delete(); exp_pc.delete();
        #1;
        check("mid_rst_req", imem_req, 0);   check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_vld", if_valid, 0);   check("mid_rst_pc", if_pc, 0);
        check("mid_rst_instr", if_instr, 0); check("mid_rst_flush", flush_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_stream(32'h0, 64);
        #1;
        check("reboot_req", imem_req, 0);
        step(1'b0, 32'h0);
        check("reboot_acc_req", log_req[cyc], 1);
        check("reboot_acc_addr", log_addr[cyc], 32'h0);
        repeat (5) step(1'b0, 32'h0);
        idr = 1'b0;
        repeat (3) step(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
